npc_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the NPC core. It fetches each instruction over a valid/ready memory handshake and decodes the RV32I fields. It drives the execute unit and register-file read port, then commits the execute result to the register file. It owns the PC, the retired-instruction counter, and the halt/trap logic for ebreak, illegal instructions and fetch timeout.

---
 rtl/npc_seq_ctrl_if.sv | 44 ++++
 rtl/npc_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_npc_seq_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/npc_seq_ctrl_if.sv
// Fetch, execute and register-file bus between the NPC sequencer and its
// surrounding memory, execute unit and register file.
interface npc_seq_ctrl_if;
  // instruction fetch handshake
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_inst;
  // execute unit
  logic [6:0]  ex_op;
  logic [2:0]  ex_funct3;
  logic [11:0] ex_imm;
  logic [31:0] ex_src1;
  logic [31:0] ex_result;
  // register file
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  // sequencer side
  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_inst,
    output ex_op, ex_funct3, ex_imm, ex_src1,
    input  ex_result,
    output rf_raddr,
    input  rf_rdata,
    output rf_wen, rf_waddr, rf_wdata
  );

  // memory / execute / register-file side
  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_rsp_valid, if_rsp_inst,
    input  ex_op, ex_funct3, ex_imm, ex_src1,
    output ex_result,
    input  rf_raddr,
    output rf_rdata,
    input  rf_wen, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/npc_seq_ctrl.sv
// Multi-cycle sequencer for the NPC core: fetch, wait, execute, write-back.
// Owns the PC, the retired-instruction counter and the halt/trap logic
// (ebreak, illegal instruction, fetch timeout).
module npc_seq_ctrl #(
  parameter logic [31:0] RESET_PC      = 32'h8000_0000,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  npc_seq_ctrl_if.master bus,
  output logic [31:0]   pc,
  output logic [31:0]   inst_cnt,
  output logic          halt,
  output logic [31:0]   halt_ret,
  output logic [1:0]    halt_cause
);

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [1:0] CAUSE_EBREAK  = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  localparam logic [15:0] TMO_LIM   = 16'(FETCH_TIMEOUT);
  localparam logic [31:0] EBREAK_IW = 32'h0010_0073;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;

  logic [2:0]  state_reg, state_next;
  logic [31:0] pc_reg;
  logic [31:0] cnt_reg;
  logic [31:0] ir_reg;
  logic [31:0] wdata_reg;
  logic [31:0] ret_reg;
  logic [1:0]  cause_reg;
  logic [15:0] tmo_reg;

  logic        is_addi;
  logic        is_ebreak;
  logic        tmo_hit;
  logic        handshake;
  logic        rsp_take;
  logic [4:0]  rd;

  // Decode is done from the latched instruction so it is stable for the
  // whole EXEC cycle regardless of what the memory bus is doing.
  assign is_addi   = (ir_reg[6:0] == OP_IMM) && (ir_reg[14:12] == 3'b000);
  assign is_ebreak = (ir_reg == EBREAK_IW);
  assign rd        = ir_reg[11:7];
  assign tmo_hit   = (tmo_reg == TMO_LIM);
  assign handshake = (state_reg == S_FETCH) && bus.if_req_ready;
  // A response is only looked at in S_WAIT, never in the handshake cycle.
  assign rsp_take  = (state_reg == S_WAIT) && bus.if_rsp_valid;

  // Next-state selection; a response on the timeout cycle still wins.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH: if (bus.if_req_ready) state_next = S_WAIT;
      S_WAIT: begin
        if (bus.if_rsp_valid)  state_next = S_EXEC;
        else if (tmo_hit)      state_next = S_HALT;
      end
      S_EXEC:  state_next = is_addi ? S_WB : S_HALT;
      S_WB:    state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_HALT;
    endcase
  end

  // State register; reset aborts any in-flight instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_FETCH;
    else     state_reg <= state_next;
  end

  // Fetch timeout counter: cleared on handshake, counts idle S_WAIT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_reg <= '0;
    end else if (handshake) begin
      tmo_reg <= '0;
    end else if ((state_reg == S_WAIT) && !bus.if_rsp_valid && !tmo_hit) begin
      tmo_reg <= tmo_reg + 16'd1;
    end
  end

  // Instruction register, loaded from the accepted fetch response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ir_reg <= '0;
    else if (rsp_take) ir_reg <= bus.if_rsp_inst;
  end

  // Write-data register captures the execute result during EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  wdata_reg <= '0;
    else if ((state_reg == S_EXEC) && is_addi) wdata_reg <= bus.ex_result;
  end

  // PC advances only when an instruction completes write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    pc_reg <= RESET_PC;
    else if (state_reg == S_WB) pc_reg <= pc_reg + 32'd4;
  end

  // Retired-instruction counter: ADDI retires in WB, ebreak in EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if ((state_reg == S_WB) || ((state_reg == S_EXEC) && is_ebreak)) begin
      cnt_reg <= cnt_reg + 32'd1;
    end
  end

  // Capture a0 (forced read address) when ebreak executes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    ret_reg <= '0;
    else if ((state_reg == S_EXEC) && is_ebreak) ret_reg <= bus.rf_rdata;
  end

  // Halt cause is written only on the transition into S_HALT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_reg <= '0;
    end else if ((state_reg == S_WAIT) && !bus.if_rsp_valid && tmo_hit) begin
      cause_reg <= CAUSE_TIMEOUT;
    end else if (state_reg == S_EXEC) begin
      if (is_ebreak)     cause_reg <= CAUSE_EBREAK;
      else if (!is_addi) cause_reg <= CAUSE_ILLEGAL;
    end
  end

  // Fetch interface: request only in S_FETCH, address quiet once halted.
  assign bus.if_req_valid = (state_reg == S_FETCH);
  assign bus.if_req_addr  = (state_reg == S_HALT) ? 32'd0 : pc_reg;

  // Execute interface is driven straight from the instruction register.
  assign bus.ex_op     = ir_reg[6:0];
  assign bus.ex_funct3 = ir_reg[14:12];
  assign bus.ex_imm    = ir_reg[31:20];
  assign bus.ex_src1   = bus.rf_rdata;

  // Register file: ebreak reads a0, everything else reads rs1.
  assign bus.rf_raddr = is_ebreak ? 5'd10 : ir_reg[19:15];
  assign bus.rf_wen   = (state_reg == S_WB) && (rd != 5'd0);
  assign bus.rf_waddr = (state_reg == S_WB) ? rd : 5'd0;
  assign bus.rf_wdata = (state_reg == S_WB) ? wdata_reg : 32'd0;

  // Status outputs.
  assign pc         = pc_reg;
  assign inst_cnt   = cnt_reg;
  assign halt       = (state_reg == S_HALT);
  assign halt_ret   = ret_reg;
  assign halt_cause = cause_reg;

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// Self-checking bench for npc_seq_ctrl: directed corner cases plus random
// ADDI streams checked against an instruction-level reference model.
module tb_npc_seq_ctrl;
  localparam int          TMO = 8;
  localparam logic [31:0] RPC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  npc_seq_ctrl_if bus();
  logic [31:0] pc, inst_cnt, halt_ret;
  logic        halt;
  logic [1:0]  halt_cause;

  npc_seq_ctrl #(.RESET_PC(RPC), .FETCH_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .pc(pc), .inst_cnt(inst_cnt), .halt(halt),
    .halt_ret(halt_ret), .halt_cause(halt_cause)
  );

  // Environment: register file with combinational read and an ADDI-only
  // execute unit.
  logic [31:0] env_rf [32] = '{default: 32'd0};
  always_comb bus.rf_rdata  = (bus.rf_raddr == 5'd0) ? 32'd0 : env_rf[bus.rf_raddr];
  always_comb bus.ex_result = bus.ex_src1 + {{20{bus.ex_imm[11]}}, bus.ex_imm};
  always @(posedge clk) if (bus.rf_wen && bus.rf_waddr != 5'd0) env_rf[bus.rf_waddr] <= bus.rf_wdata;

  // Reference model: architectural state only.
  logic [31:0] ref_rf [32];
  logic [31:0] ref_pc, ref_cnt;
  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.if_req_ready = 1'b0;
    bus.if_rsp_valid = 1'b0;
    bus.if_rsp_inst  = $urandom;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ref_pc  = RPC;
    ref_cnt = 0;
  endtask

  // Present the request; hold ready low for rdy_dly cycles first.
  task automatic fetch_phase(input int rdy_dly);
    for (int k = 0; k <= rdy_dly; k++) begin
      chk("req_valid", {31'd0, bus.if_req_valid}, 32'd1);
      chk("req_addr", bus.if_req_addr, ref_pc);
      bus.if_req_ready = (k == rdy_dly);
      @(negedge clk);
    end
    bus.if_req_ready = 1'b0;
    chk("wait_req_valid", {31'd0, bus.if_req_valid}, 32'd0);
  endtask

  // Once halted, the core must stay silent whatever the bus does.
  task automatic check_halted(input logic [1:0] cause);
    for (int k = 0; k < 5; k++) begin
      chk("halt", {31'd0, halt}, 32'd1);
      chk("halt_cause", {30'd0, halt_cause}, {30'd0, cause});
      chk("halt_req_valid", {31'd0, bus.if_req_valid}, 32'd0);
      chk("halt_wen", {31'd0, bus.rf_wen}, 32'd0);
      chk("halt_pc", pc, ref_pc);
      chk("halt_cnt", inst_cnt, ref_cnt);
      bus.if_req_ready = 1'($urandom);
      bus.if_rsp_valid = 1'($urandom);
      bus.if_rsp_inst  = $urandom;
      @(negedge clk);
    end
    bus.if_req_ready = 1'b0;
    bus.if_rsp_valid = 1'b0;
  endtask

  // One instruction from fetch to retirement (or halt). abort_wb pulses
  // reset in the write-back cycle.
  task automatic run_instr(input logic [31:0] inst, input int rdy_dly, input int rsp_dly, input bit abort_wb);
    logic        is_eb, is_addi;
    logic [4:0]  rs, rd;
    logic [31:0] val;
    is_eb   = (inst == 32'h0010_0073);
    is_addi = (inst[6:0] == 7'b0010011) && (inst[14:12] == 3'b000);
    rd      = inst[11:7];
    rs      = is_eb ? 5'd10 : inst[19:15];
    val     = ref_rf[inst[19:15]] + {{20{inst[31]}}, inst[31:20]};
    fetch_phase(rdy_dly);
    for (int j = 0; j <= rsp_dly; j++) begin
      chk("wait_nohalt", {31'd0, halt}, 32'd0);
      if (j == rsp_dly) begin
        bus.if_rsp_valid = 1'b1;
        bus.if_rsp_inst  = inst;
      end
      @(negedge clk);
    end
    bus.if_rsp_valid = 1'b0;
    bus.if_rsp_inst  = $urandom;
    // execute cycle
    chk("ex_op", {25'd0, bus.ex_op}, {25'd0, inst[6:0]});
    chk("ex_funct3", {29'd0, bus.ex_funct3}, {29'd0, inst[14:12]});
    chk("ex_imm", {20'd0, bus.ex_imm}, {20'd0, inst[31:20]});
    chk("rf_raddr", {27'd0, bus.rf_raddr}, {27'd0, rs});
    chk("ex_src1", bus.ex_src1, ref_rf[rs]);
    chk("exec_wen", {31'd0, bus.rf_wen}, 32'd0);
    @(negedge clk);
    if (is_addi) begin
      chk("wb_wen", {31'd0, bus.rf_wen}, {31'd0, rd != 5'd0});
      if (rd != 5'd0) begin
        chk("wb_waddr", {27'd0, bus.rf_waddr}, {27'd0, rd});
        chk("wb_wdata", bus.rf_wdata, val);
      end
      if (abort_wb) begin
        rst = 1'b1;
        #1;
        chk("abort_wen", {31'd0, bus.rf_wen}, 32'd0);
        chk("abort_pc", pc, RPC);
        @(negedge clk);
        rst = 1'b0;
        ref_pc  = RPC;
        ref_cnt = 0;
        chk("abort_cnt", inst_cnt, 32'd0);
      end else begin
        if (rd != 5'd0) ref_rf[rd] = val;
        ref_pc  = ref_pc + 32'd4;
        ref_cnt = ref_cnt + 32'd1;
        @(negedge clk);
        chk("pc", pc, ref_pc);
        chk("inst_cnt", inst_cnt, ref_cnt);
        chk("run_halt", {31'd0, halt}, 32'd0);
      end
      $display("instr %h rd=%0d -> pc=%h cnt=%0d", inst, rd, pc, inst_cnt);
    end else if (is_eb) begin
      ref_cnt = ref_cnt + 32'd1;
      chk("halt_ret", halt_ret, ref_rf[10]);
      $display("ebreak a0=%h cnt=%0d", halt_ret, inst_cnt);
      check_halted(2'd1);
    end else begin
      $display("illegal %h pc=%h", inst, pc);
      check_halted(2'd2);
    end
  endtask

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs, input logic [11:0] imm);
    return {imm, rs, 3'b000, rd, 7'b0010011};
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    do_reset();
    // reset state
    chk("rst_pc", pc, RPC);
    chk("rst_cnt", inst_cnt, 32'd0);
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_cause", {30'd0, halt_cause}, 32'd0);
    chk("rst_ret", halt_ret, 32'd0);
    chk("rst_req_valid", {31'd0, bus.if_req_valid}, 32'd1);
    chk("rst_wen", {31'd0, bus.rf_wen}, 32'd0);
    chk("rst_ex_op", {25'd0, bus.ex_op}, 32'd0);

    // minimum-latency ADDI x1,x0,5, then stalled ready, then rd=x0
    run_instr(32'h0050_0093, 0, 0, 1'b0);
    run_instr(addi(5'd2, 5'd1, 12'hFFD), 3, 1, 1'b0);
    run_instr(32'h0070_0013, 0, 0, 1'b0);

    // random ADDI stream, response delays up to the timeout limit
    for (int n = 0; n < 30; n++) begin
      run_instr(addi(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 12'($urandom)),
                $urandom_range(0, 3), $urandom_range(0, TMO), 1'b0);
    end
    // response exactly on the limit cycle
    run_instr(addi(5'd5, 5'd2, 12'h123), 0, TMO, 1'b0);

    // reset pulse in write-back: x3 must keep its old value
    run_instr(addi(5'd3, 5'd0, 12'd99), 1, 0, 1'b1);
    run_instr(addi(5'd4, 5'd3, 12'd0), 0, 2, 1'b0);

    // ebreak with a0 = 42
    run_instr(addi(5'd10, 5'd0, 12'h02A), 0, 0, 1'b0);
    run_instr(32'h0010_0073, 2, 1, 1'b0);

    // illegal instruction
    do_reset();
    run_instr(32'h0000_0033, 0, 0, 1'b0);

    // fetch timeout: no response ever arrives
    do_reset();
    run_instr(addi(5'd6, 5'd4, 12'h001), 0, 0, 1'b0);
    fetch_phase(1);
    for (int j = 0; j <= TMO; j++) begin
      chk("tmo_nohalt", {31'd0, halt}, 32'd0);
      @(negedge clk);
    end
    $display("timeout pc=%h cause=%0d", pc, halt_cause);
    check_halted(2'd3);

    // recovery after reset
    do_reset();
    run_instr(addi(5'd7, 5'd6, 12'h800), 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
